// File: rtl/fpdiv_vec_seq.sv
// Self-test initiator for fpdiv: replays ROM vectors through the start/done protocol and scores results.
// Optional flag comparison and sticky flag_err output are enabled with FPDIV_FLAG_CHECK_EN.
module fpdiv_vec_seq #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W:0]   num_vec,
    input  logic [2:0]        cfg_rm,
    input  logic              cfg_op_type,
    input  logic              cfg_P,
    input  logic              cfg_OvEn,
    input  logic              cfg_UnEn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [103:0]      rom_data,
    output logic [63:0]       op1,
    output logic [63:0]       op2,
    output logic [2:0]        rm,
    output logic              op_type,
    output logic              P,
    output logic              OvEn,
    output logic              UnEn,
    output logic              start,
    input  logic              done,
    input  logic [63:0]       AS_Result,
    input  logic [4:0]        Flags,
    input  logic              Denorm,
    output logic              busy,
    output logic              finished,
    output logic              pass,
    output logic [ADDR_W:0]   vec_count,
    output logic [ADDR_W:0]   err_count
`ifdef FPDIV_FLAG_CHECK_EN
    ,
    output logic              flag_err
`endif
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned SW = (START_CYCLES < 1) ? 1 : $clog2(START_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CHECK, S_FIN
    } state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_num_vec, w_num_clamp, w_vec_inc;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [31:0]        r_op1, r_op2, r_yexp, r_res;
    logic [2:0]         r_rm;
    logic               r_op_type, r_P, r_OvEn, r_UnEn;
    logic               r_start, r_busy, r_finished, r_pass, r_tmo;
    logic [SW-1:0]      r_scnt;
    logic [TW-1:0]      r_tmr;
    logic [CW-1:0]      r_vec_count, r_err_count;
    logic               w_accept, w_capture, w_tmo, w_check, w_mismatch, w_fin_next;
`ifdef FPDIV_FLAG_CHECK_EN
    logic [4:0]         r_fexp, r_flags;
    logic               r_flag_err, w_flag_only;
`endif

    // Inputs the comparison never looks at; Denorm is observe-only.
    logic w_unused;
    assign w_unused = ^{Denorm, AS_Result[31:0], rom_data[7:0], Flags};

    assign w_num_clamp = (num_vec > (CW'(1) << ADDR_W)) ? (CW'(1) << ADDR_W) : num_vec;
    assign w_vec_inc   = r_vec_count + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_tmo        = 1'b0;
        w_check      = 1'b0;
        w_mismatch   = r_tmo | (r_res != r_yexp);
`ifdef FPDIV_FLAG_CHECK_EN
        w_flag_only  = !r_tmo && (r_res == r_yexp) && (r_flags != r_fexp);
        w_mismatch   = w_mismatch | (r_flags != r_fexp);
`endif
        case (r_state)
            S_IDLE, S_FIN: begin
                if (go) begin
                    w_accept     = 1'b1;
                    w_state_next = (num_vec == '0) ? S_FIN : S_FETCH;
                end else if (r_state == S_FIN) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_START;
            S_START: if (r_scnt == SW'(START_CYCLES)) w_state_next = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    w_capture    = 1'b1;
                    w_state_next = S_CHECK;
                end else if (r_tmr == TW'(TIMEOUT - 1)) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check      = 1'b1;
                w_state_next = (w_vec_inc == r_num_vec) ? S_FIN : S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_fin_next = w_accept ? 1'b0 : ((r_state == S_FIN) ? 1'b1 : r_finished);
    end

    // Datapath, counters and registered status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num_vec   <= '0;  r_rom_addr <= '0;
            r_op1       <= '0;  r_op2      <= '0;  r_yexp <= '0;  r_res <= '0;
            r_rm        <= '0;  r_op_type  <= 1'b0; r_P   <= 1'b0;
            r_OvEn      <= 1'b0; r_UnEn    <= 1'b0;
            r_start     <= 1'b0; r_busy    <= 1'b0; r_finished <= 1'b0;
            r_pass      <= 1'b0; r_tmo     <= 1'b0;
            r_scnt      <= '0;  r_tmr      <= '0;
            r_vec_count <= '0;  r_err_count <= '0;
`ifdef FPDIV_FLAG_CHECK_EN
            r_fexp      <= '0;  r_flags <= '0;  r_flag_err <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_num_vec   <= w_num_clamp;
                r_rm        <= cfg_rm;
                r_op_type   <= cfg_op_type;
                r_P         <= cfg_P;
                r_OvEn      <= cfg_OvEn;
                r_UnEn      <= cfg_UnEn;
                r_rom_addr  <= '0;
                r_vec_count <= '0;
                r_err_count <= '0;
`ifdef FPDIV_FLAG_CHECK_EN
                r_flag_err  <= 1'b0;
`endif
            end
            if (r_state == S_LOAD) begin
                r_op1  <= rom_data[103:72];
                r_op2  <= rom_data[71:40];
                r_yexp <= rom_data[39:8];
`ifdef FPDIV_FLAG_CHECK_EN
                r_fexp <= rom_data[4:0];
`endif
            end
            // start rises one cycle after operands settle and falls on WAIT entry.
            if (r_state == S_START) begin
                if (r_scnt == SW'(START_CYCLES)) begin
                    r_start <= 1'b0;
                    r_scnt  <= '0;
                end else begin
                    r_start <= 1'b1;
                    r_scnt  <= r_scnt + SW'(1);
                end
            end
            r_tmr <= (r_state == S_WAIT) ? r_tmr + TW'(1) : '0;
            if (r_state == S_WAIT) r_tmo <= w_tmo;
            if (w_capture) begin
                r_res <= AS_Result[63:32];
`ifdef FPDIV_FLAG_CHECK_EN
                r_flags <= Flags;
`endif
            end
            if (w_check) begin
                r_vec_count <= w_vec_inc;
                r_rom_addr  <= r_rom_addr + ADDR_W'(1);
                if (w_mismatch && (r_err_count != '1)) r_err_count <= r_err_count + CW'(1);
`ifdef FPDIV_FLAG_CHECK_EN
                if (w_flag_only) r_flag_err <= 1'b1;
`endif
            end
            r_busy     <= (w_state_next != S_IDLE) && (w_state_next != S_FIN);
            r_finished <= w_fin_next;
            r_pass     <= w_fin_next && (r_err_count == '0);
        end
    end

    assign rom_addr  = r_rom_addr;
    assign op1       = {r_op1, 32'h0};
    assign op2       = {r_op2, 32'h0};
    assign rm        = r_rm;
    assign op_type   = r_op_type;
    assign P         = r_P;
    assign OvEn      = r_OvEn;
    assign UnEn      = r_UnEn;
    assign start     = r_start;
    assign busy      = r_busy;
    assign finished  = r_finished;
    assign pass      = r_pass;
    assign vec_count = r_vec_count;
    assign err_count = r_err_count;
`ifdef FPDIV_FLAG_CHECK_EN
    assign flag_err  = r_flag_err;
`endif

endmodule

// File: tb/tb_fpdiv_vec_seq.sv
// Directed bench for fpdiv_vec_seq: ROM model plus a behavioural divider responder.
module tb_fpdiv_vec_seq;

    logic         clk = 1'b0;
    logic         reset, go;
    logic [16:0]  num_vec;
    logic [2:0]   cfg_rm;
    logic         cfg_op_type, cfg_P, cfg_OvEn, cfg_UnEn;
    logic [15:0]  rom_addr;
    logic [103:0] rom_data;
    logic [63:0]  op1, op2, AS_Result;
    logic [2:0]   rm;
    logic         op_type, P, OvEn, UnEn, start, done, Denorm;
    logic [4:0]   Flags;
    logic         busy, finished, pass;
    logic [16:0]  vec_count, err_count;
`ifdef FPDIV_FLAG_CHECK_EN
    logic         flag_err;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [103:0] rom [0:7];
    logic [31:0]  resp_res [0:7];
    logic [4:0]   resp_flags [0:7];
    logic         resp_en [0:7];
    logic [15:0]  addr_log [0:7];
    int start_rises = 0, start_falls = 0, last_hi = 0, t_at_vc = 0;

    always #5 clk = ~clk;

    fpdiv_vec_seq #(.ADDR_W(16), .START_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .go(go), .num_vec(num_vec),
        .cfg_rm(cfg_rm), .cfg_op_type(cfg_op_type), .cfg_P(cfg_P),
        .cfg_OvEn(cfg_OvEn), .cfg_UnEn(cfg_UnEn),
        .rom_addr(rom_addr), .rom_data(rom_data), .op1(op1), .op2(op2),
        .rm(rm), .op_type(op_type), .P(P), .OvEn(OvEn), .UnEn(UnEn),
        .start(start), .done(done), .AS_Result(AS_Result), .Flags(Flags), .Denorm(Denorm),
        .busy(busy), .finished(finished), .pass(pass),
        .vec_count(vec_count), .err_count(err_count)
`ifdef FPDIV_FLAG_CHECK_EN
        , .flag_err(flag_err)
`endif
    );

    // Synchronous vector ROM, one cycle read latency.
    always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

    // Responder: done pulses a few cycles after start falls, unless disabled for that address.
    initial begin : responder
        int cnt, cur_hi, t_fall;
        logic prev_start;
        logic [16:0] prev_vc;
        logic [2:0] idx;
        cnt = 0; cur_hi = 0; t_fall = 0; prev_start = 1'b0; prev_vc = '0; idx = '0;
        done = 1'b0; AS_Result = '0; Flags = '0; Denorm = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0; cur_hi = 0; done = 1'b0; prev_start = 1'b0;
            end else begin
                done = 1'b0;
                if (start) begin
                    cur_hi++;
                    if (!prev_start) begin
                        addr_log[start_rises[2:0]] = rom_addr;
                        start_rises++;
                    end
                end
                if (prev_start && !start) begin
                    last_hi = cur_hi; cur_hi = 0; start_falls++; t_fall = 0;
                    idx = rom_addr[2:0];
                    if (resp_en[idx]) cnt = 5;
                end else begin
                    t_fall++;
                end
                if (vec_count != prev_vc) t_at_vc = t_fall;
                prev_vc = vec_count;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        done = 1'b1;
                        AS_Result = {resp_res[idx], 32'h0};
                        Flags = resp_flags[idx];
                    end
                end
                prev_start = start;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go(input logic [16:0] nv);
        @(negedge clk);
        num_vec = nv; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_finished(input int budget, input string tag);
        int n = 0;
        while (!finished && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(finished), 64'd1);
    endtask

    function automatic logic [103:0] vec(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] y, input logic [7:0] f);
        return {a, b, y, f};
    endfunction

    initial begin : main
        int base;
        reset = 1'b0; go = 1'b0; num_vec = '0;
        cfg_rm = 3'b101; cfg_op_type = 1'b1; cfg_P = 1'b0; cfg_OvEn = 1'b1; cfg_UnEn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rom[i] = '0; resp_res[i] = 32'h3F000000; resp_flags[i] = '0; resp_en[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_status", 64'({finished, pass, rom_addr, vec_count, err_count}), 64'd0);
        chk("rst_ops", op1 | op2 | 64'({rm, op_type, P, OvEn, UnEn}), 64'd0);
        reset = 1'b1;

        // Single vector 1.0 / 2.0 = 0.5.
        rom[0] = vec(32'h3F800000, 32'h40000000, 32'h3F000000, 8'h00);
        pulse_go(17'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_finished(200, "t1_finished");
        chk("t1_start_hi", 64'(last_hi), 64'd2);
        chk("t1_vec", 64'(vec_count), 64'd1);
        chk("t1_err", 64'(err_count), 64'd0);
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_op1", op1, 64'h3F800000_00000000);
        chk("t1_op2", op2, 64'h40000000_00000000);
        chk("t1_cfg", 64'({rm, op_type, P, OvEn, UnEn}), 64'b101_1_0_1_0);
        chk("t1_addr", 64'(rom_addr), 64'd1);

        // Three vectors, middle result off by one ulp.
        rom[1] = vec(32'h40400000, 32'h40C00000, 32'h3F000000, 8'h00);
        rom[2] = vec(32'h40800000, 32'h41000000, 32'h3F000000, 8'h00);
        resp_res[1] = 32'h3F000001;
        base = start_rises;
        pulse_go(17'd3);
        wait_finished(400, "t2_finished");
        chk("t2_vec", 64'(vec_count), 64'd3);
        chk("t2_err", 64'(err_count), 64'd1);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_addr0", 64'(addr_log[3'(base)]), 64'd0);
        chk("t2_addr1", 64'(addr_log[3'(base + 1)]), 64'd1);
        chk("t2_addr2", 64'(addr_log[3'(base + 2)]), 64'd2);
        chk("t2_addr_end", 64'(rom_addr), 64'd3);
        resp_res[1] = 32'h3F000000;

        // Responder silent: timeout forces an error.
        resp_en[0] = 1'b0;
        pulse_go(17'd1);
        wait_finished(300, "t3_finished");
        chk("t3_check_time", 64'(t_at_vc), 64'd65);
        chk("t3_vec", 64'(vec_count), 64'd1);
        chk("t3_err", 64'(err_count), 64'd1);
        chk("t3_pass", 64'(pass), 64'd0);
        resp_en[0] = 1'b1;

        // Zero-length run.
        base = start_rises;
        pulse_go(17'd0);
        chk("t4_fin_early", 64'(finished), 64'd0);
        @(negedge clk);
        chk("t4_fin", 64'(finished), 64'd1);
        chk("t4_pass", 64'(pass), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_no_start", 64'(start_rises), 64'(base));

        // Asynchronous reset while waiting on vector 2, then a clean rerun.
        base = start_falls;
        pulse_go(17'd3);
        for (int n = 0; n < 200 && start_falls < base + 2; n++) @(negedge clk);
        chk("t5_reached_wait", 64'(start_falls), 64'(base + 2));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_rst_start", 64'(start), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_cnt", 64'({vec_count, err_count, rom_addr}), 64'd0);
        chk("t5_rst_op1", op1, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        base = start_rises;
        pulse_go(17'd2);
        wait_finished(300, "t5_finished");
        chk("t5_first_addr", 64'(addr_log[3'(base)]), 64'd0);
        chk("t5_vec", 64'(vec_count), 64'd2);
        chk("t5_pass", 64'(pass), 64'd1);

        // Result matches, flags differ from expectation.
        resp_flags[0] = 5'b00001;
        pulse_go(17'd1);
        wait_finished(200, "t6_finished");
`ifdef FPDIV_FLAG_CHECK_EN
        chk("t6_err", 64'(err_count), 64'd1);
        chk("t6_flag_err", 64'(flag_err), 64'd1);
`else
        chk("t6_err", 64'(err_count), 64'd0);
        chk("t6_pass", 64'(pass), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
